// File: rtl/free_list_pkg.sv
// free_list_pkg: shared defaults, slot index type and popcount helper for the free-list allocator
package free_list_pkg;
    localparam int DEPTH_DEF = 8;
    localparam int IDX_DEF   = $clog2(DEPTH_DEF);
    typedef logic [IDX_DEF-1:0] idx_t;
    function automatic int popcount(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) n += int'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/pri_enc.sv
// pri_enc: priority encoder returning the highest-numbered active request bit
module pri_enc #(
    parameter int IN  = 8,
    parameter int OUT = $clog2(IN),
    parameter bit ACT = 1'b1
) (
    input  logic [IN-1:0]  req_i,
    output logic [OUT-1:0] idx_o,
    output logic           valid_o
);
    logic [IN-1:0] req;
    assign req = ACT ? req_i : ~req_i;
    // Scan upward so the last (highest) active bit wins; index stays 0 when nothing is active.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < IN; i++) begin
            if (req[i]) begin
                idx_o   = OUT'(i);
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/free_list_alloc.sv
// free_list_alloc: slot allocator with free bitmap, highest-free grant and occupancy count (FREE_LIST_BYPASS_EN enables release-to-grant bypass when full)
module free_list_alloc
    import free_list_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX   = $clog2(DEPTH),
    parameter int CNT   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           alloc_req,
    output logic           alloc_ready,
    output logic [IDX-1:0] alloc_idx,
    input  logic           free_valid,
    input  logic [IDX-1:0] free_idx,
    output logic [CNT-1:0] used_cnt,
    output logic           full,
    output logic           empty,
    output logic           err
);
    logic [DEPTH-1:0] free_q, free_d;
    logic [CNT-1:0]   cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [IDX-1:0]   enc_idx;
    logic             enc_valid;
    logic             in_rng, legal_rel, grant;

    pri_enc #(.IN(DEPTH), .OUT(IDX), .ACT(1'b1)) u_enc (
        .req_i   (free_q),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign in_rng    = int'(free_idx) < DEPTH;
    assign legal_rel = free_valid && in_rng && !free_q[free_idx];

`ifdef FREE_LIST_BYPASS_EN
    // Encoder is invalid only when every slot is busy; then a legal release can be granted straight through.
    logic byp;
    assign byp         = !enc_valid && legal_rel;
    assign alloc_ready = enc_valid || byp;
    assign alloc_idx   = byp ? free_idx : enc_idx;
`else
    assign alloc_ready = enc_valid;
    assign alloc_idx   = enc_idx;
`endif

    assign grant    = alloc_req && alloc_ready;
    assign used_cnt = cnt_q;
    assign full     = cnt_q == CNT'(DEPTH);
    assign empty    = cnt_q == '0;
    assign err      = err_q;

    // Release sets before grant clears, so a bypassed slot ends up busy; flush overrides map and count but not err.
    always_comb begin
        free_d = free_q;
        if (legal_rel) free_d[free_idx] = 1'b1;
        if (grant) free_d[alloc_idx] = 1'b0;
        cnt_d = cnt_q + CNT'(grant) - CNT'(legal_rel);
        err_d = free_valid && !legal_rel;
        if (flush) begin
            free_d = '1;
            cnt_d  = '0;
        end
    end

    // State registers with synchronous reset to all-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            free_q <= '1;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            free_q <= free_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Occupancy count must always mirror the number of busy bits in the map.
    a_cnt_matches_map: assert property (@(posedge clk) disable iff (reset)
        int'(cnt_q) == DEPTH - popcount(64'(free_q)));
endmodule

// File: tb/tb_free_list_alloc.sv
// tb_free_list_alloc: table-driven and directed checks of free_list_alloc plus a randomized model comparison
module tb_free_list_alloc;
    logic       clk = 1'b0;
    logic       reset, flush, alloc_req, free_valid;
    logic [2:0] free_idx, alloc_idx;
    logic       alloc_ready, full, empty, err;
    logic [3:0] used_cnt;
    logic       req6, fv6, rdy6, full6, empty6, err6;
    logic [2:0] fi6, idx6, cnt6;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        logic       fl, rq, fv;
        logic [2:0] fi;
        logic       rdy;
        logic [2:0] idx;
        logic [3:0] cnt;
        logic       fu, em, er;
    } vec_t;
    vec_t tv[19];

    always #5 clk = ~clk;

    free_list_alloc #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset), .flush(flush), .alloc_req(alloc_req),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx), .free_valid(free_valid),
        .free_idx(free_idx), .used_cnt(used_cnt), .full(full), .empty(empty), .err(err)
    );

    free_list_alloc #(.DEPTH(6)) dut6 (
        .clk(clk), .reset(reset), .flush(flush), .alloc_req(req6),
        .alloc_ready(rdy6), .alloc_idx(idx6), .free_valid(fv6),
        .free_idx(fi6), .used_cnt(cnt6), .full(full6), .empty(empty6), .err(err6)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {21'b0, alloc_ready, alloc_idx, used_cnt, full, empty, err};
    endfunction

    function automatic logic [31:0] pk(input bit rdy, input int idx, input int cnt, input bit fu, input bit em, input bit er);
        return {21'b0, rdy, 3'(idx), 4'(cnt), fu, em, er};
    endfunction

    task automatic drv(input logic f, input logic r, input logic v, input logic [2:0] i);
        flush = f; alloc_req = r; free_valid = v; free_idx = i;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv(0, 0, 0, 0);
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        drv(0, 1, 0, 0);
        repeat (n) cyc();
        drv(0, 0, 0, 0);
    endtask

    task automatic setv(input int k, input bit fl, input bit rq, input bit fv, input int fi,
                        input bit rdy, input int idx, input int cnt, input bit fu, input bit em, input bit er);
        tv[k] = '{fl, rq, fv, 3'(fi), rdy, 3'(idx), 4'(cnt), fu, em, er};
    endtask

    initial begin
        logic [7:0] m, nm;
        int         ecnt, eidx, fi;
        bit         erdy, eerr, legal, r, fl, fv;
        req6 = 1'b0; fv6 = 1'b0; fi6 = '0;
        // Rows: inputs for a cycle and the outputs expected during that same cycle.
        for (int i = 0; i < 8; i++) setv(i, 0, 1, 0, 0, 1, 7 - i, i, 0, i == 0, 0);
        setv(8,  0, 0, 0, 0, 0, 0, 8, 1, 0, 0);
        setv(9,  1, 0, 0, 0, 0, 0, 8, 1, 0, 0);
        setv(10, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0);
        setv(11, 0, 0, 1, 2, 1, 7, 0, 0, 1, 0);
        setv(12, 0, 0, 0, 0, 1, 7, 0, 0, 1, 1);
        setv(13, 0, 1, 0, 0, 1, 7, 0, 0, 1, 0);
        setv(14, 0, 1, 0, 0, 1, 6, 1, 0, 0, 0);
        setv(15, 0, 1, 1, 7, 1, 5, 2, 0, 0, 0);
        setv(16, 0, 0, 0, 0, 1, 7, 2, 0, 0, 0);
        setv(17, 0, 1, 0, 0, 1, 7, 2, 0, 0, 0);
        setv(18, 0, 0, 0, 0, 1, 4, 3, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 19; i++) begin
            drv(tv[i].fl, tv[i].rq, tv[i].fv, tv[i].fi);
            #1;
            chk($sformatf("vec%0d", i), outs(),
                {21'b0, tv[i].rdy, tv[i].idx, tv[i].cnt, tv[i].fu, tv[i].em, tv[i].er});
            cyc();
        end

        // Release into a full map with a request pending.
        do_reset();
        alloc_n(8);
        drv(0, 1, 1, 3);
        #1;
`ifdef FREE_LIST_BYPASS_EN
        chk("full_rel_same", outs(), pk(1, 3, 8, 1, 0, 0));
`else
        chk("full_rel_same", outs(), pk(0, 0, 8, 1, 0, 0));
`endif
        cyc();
        drv(0, 0, 0, 0);
        #1;
`ifdef FREE_LIST_BYPASS_EN
        chk("full_rel_next", outs(), pk(0, 0, 8, 1, 0, 0));
`else
        chk("full_rel_next", outs(), pk(1, 3, 7, 0, 0, 0));
`endif
        cyc();

        // Flush beats a simultaneous request.
        do_reset();
        alloc_n(5);
        drv(1, 1, 0, 0);
        #1;
        chk("pre_flush", outs(), pk(1, 2, 5, 0, 0, 0));
        cyc();
        drv(0, 0, 0, 0);
        #1;
        chk("post_flush", outs(), pk(1, 7, 0, 0, 1, 0));
        cyc();

        // Reset mid-sequence with an illegal release in the same cycle.
        do_reset();
        alloc_n(4);
        reset = 1'b1;
        drv(0, 1, 1, 0);
        cyc();
        reset = 1'b0;
        drv(0, 0, 0, 0);
        #1;
        chk("mid_reset", outs(), pk(1, 7, 0, 0, 1, 0));
        cyc();
        #1;
        chk("mid_reset_hold", outs(), pk(1, 7, 0, 0, 1, 0));

        // DEPTH=6: out-of-range release pulses err for one cycle only.
        do_reset();
        fv6 = 1'b1; fi6 = 3'd7;
        cyc();
        fv6 = 1'b0; fi6 = 3'd0;
        #1;
        chk("d6_err_hi", {26'b0, rdy6, idx6, err6, empty6}, {26'b0, 1'b1, 3'd5, 1'b1, 1'b1});
        chk("d6_cnt", {29'b0, cnt6}, 32'd0);
        cyc();
        #1;
        chk("d6_err_lo", {26'b0, rdy6, idx6, err6, full6}, {26'b0, 1'b1, 3'd5, 1'b0, 1'b0});

        // Random run against an independent map model.
        do_reset();
        m = 8'hFF; ecnt = 0; eerr = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            r  = $urandom_range(0, 9) < 6;
            fl = $urandom_range(0, 199) == 0;
            fv = $urandom_range(0, 1) == 1;
            fi = $urandom_range(0, 7);
            if (m != 8'hFF && $urandom_range(0, 3) != 0)
                while (m[fi]) fi = $urandom_range(0, 7);
            legal = fv && !m[fi];
            erdy = 1'b0; eidx = 0;
            for (int i = 0; i < 8; i++) if (m[i]) begin erdy = 1'b1; eidx = i; end
`ifdef FREE_LIST_BYPASS_EN
            if (m == 8'h00 && legal) begin erdy = 1'b1; eidx = fi; end
`endif
            drv(fl, r, fv, 3'(fi));
            #1;
            chk($sformatf("rand%0d", c), {19'b0, alloc_ready, alloc_idx, used_cnt, err, full, empty},
                {19'b0, erdy, 3'(eidx), 4'(ecnt), eerr, ecnt == 8, ecnt == 0});
            nm = m;
            if (legal) nm[fi] = 1'b1;
            if (r && erdy) nm[eidx] = 1'b0;
            ecnt = ecnt + int'(r && erdy) - int'(legal);
            eerr = fv && !legal;
            if (fl) begin nm = 8'hFF; ecnt = 0; end
            m = nm;
            cyc();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
